// File: rtl/player_state_rx_pkg.sv
// Shared definitions for the inter-FPGA player-state link (receiver and transmitter).
package player_state_rx_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned PKT_LEN   = 6;

  // Packet framing progress: named after the last byte accepted.
  typedef enum logic [2:0] {
    StHunt,
    StGotSync,
    StGotB1,
    StGotB2,
    StGotB3,
    StGotB4
  } pkt_state_e;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [1:0] dir;
    logic [3:0] state;
  } player_field_t;

  // Checksum over the four payload bytes.
  function automatic logic [7:0] pkt_checksum(input logic [7:0] b1, input logic [7:0] b2,
                                              input logic [7:0] b3, input logic [7:0] b4);
    return b1 ^ b2 ^ b3 ^ b4;
  endfunction

endpackage

// File: rtl/player_state_rx_uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, mid-bit sampling, start glitch and stop checks.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       frame_err
);

  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxWaitHigh
  } rx_state_e;

  logic            sync1_q, sync2_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  // Receiver state, bit timer, shift register and registered strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RxIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state: start is re-checked at half a bit, later bits are sampled a full bit apart.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (!sync2_q) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          // Line back high at mid start bit: a glitch, silently ignored.
          state_d = sync2_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RxStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (sync2_q) begin
            byte_valid_d = 1'b1;
            state_d      = RxIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RxWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxWaitHigh: begin
        // A held-low line (break) yields one error, not a stream of them.
        if (sync2_q) state_d = RxIdle;
      end
      default: state_d = RxIdle;
    endcase
  end

  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign data       = shift_q;

endmodule

// File: rtl/player_state_rx.sv
// Player-state link receiver: frames UART bytes into 6-byte packets and keeps per-player registers.
module player_state_rx
  import player_state_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 25_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            rx_in,
  input  logic [1:0]      local_player_ID,
  output logic [3:0][8:0] player_x,
  output logic [3:0][8:0] player_y,
  output logic [3:0][1:0] player_dir,
  output logic [3:0][3:0] player_state,
  output logic [3:0]      player_valid,
  output logic            update_pulse,
  output logic [1:0]      update_id,
  output logic [7:0]      crc_err_count,
  output logic [7:0]      frame_err_count
);

  localparam int unsigned TmoCycles = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TmoW      = $clog2(TmoCycles + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TmoCycles - 1);

  logic          byte_valid;
  logic [7:0]    rx_data;
  logic          frame_err;

  pkt_state_e    state_q, state_d;
  logic [1:0]    id_q, id_d;
  player_field_t fields_q, fields_d;
  logic [7:0]    csum_q, csum_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic          commit;
  logic          crc_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx_in     (rx_in),
    .byte_valid(byte_valid),
    .data      (rx_data),
    .frame_err (frame_err)
  );

  // Packet FSM state, shadow fields, running checksum and idle timer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StHunt;
      id_q     <= '0;
      fields_q <= '0;
      csum_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      fields_q <= fields_d;
      csum_q   <= csum_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state: one state per accepted byte; framing errors and idle timeouts abandon the packet.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    fields_d = fields_q;
    csum_d   = csum_q;
    tmo_d    = (state_q == StHunt || byte_valid) ? '0 : tmo_q + 1'b1;
    commit   = 1'b0;
    crc_err  = 1'b0;
    if (frame_err) begin
      state_d = StHunt;
    end else if (byte_valid) begin
      unique case (state_q)
        StHunt: begin
          if (rx_data == SYNC_BYTE) state_d = StGotSync;
        end
        StGotSync: begin
          id_d           = rx_data[7:6];
          fields_d.dir   = rx_data[5:4];
          fields_d.state = rx_data[3:0];
          csum_d         = rx_data;
          state_d        = StGotB1;
        end
        StGotB1: begin
          fields_d.x[7:0] = rx_data;
          csum_d          = csum_q ^ rx_data;
          state_d         = StGotB2;
        end
        StGotB2: begin
          // Low six bits are reserved; they only feed the checksum.
          fields_d.x[8] = rx_data[7];
          fields_d.y[8] = rx_data[6];
          csum_d        = csum_q ^ rx_data;
          state_d       = StGotB3;
        end
        StGotB3: begin
          fields_d.y[7:0] = rx_data;
          csum_d          = csum_q ^ rx_data;
          state_d         = StGotB4;
        end
        StGotB4: begin
          if (rx_data == csum_q) begin
            commit = (id_q != local_player_ID);
          end else begin
            crc_err = 1'b1;
          end
          state_d = StHunt;
        end
        default: state_d = StHunt;
      endcase
    end else if (state_q != StHunt && tmo_q == TmoLast) begin
      state_d = StHunt;
    end
  end

  // Player register file, commit strobe and saturating error counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      player_x        <= '0;
      player_y        <= '0;
      player_dir      <= '0;
      player_state    <= '0;
      player_valid    <= '0;
      update_pulse    <= 1'b0;
      update_id       <= '0;
      crc_err_count   <= '0;
      frame_err_count <= '0;
    end else begin
      update_pulse <= commit;
      if (commit) begin
        player_x[id_q]     <= fields_q.x;
        player_y[id_q]     <= fields_q.y;
        player_dir[id_q]   <= fields_q.dir;
        player_state[id_q] <= fields_q.state;
        player_valid[id_q] <= 1'b1;
        update_id          <= id_q;
      end
      if (crc_err && crc_err_count != 8'hFF) crc_err_count <= crc_err_count + 1'b1;
      if (frame_err && frame_err_count != 8'hFF) frame_err_count <= frame_err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_player_state_rx.sv
// Self-checking bench for player_state_rx against a packet-level reference model.
module tb_player_state_rx;

  localparam int unsigned CPB = 4;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            rx_in = 1'b1;
  logic [1:0]      local_id = 2'd0;
  logic [3:0][8:0] player_x, player_y;
  logic [3:0][1:0] player_dir;
  logic [3:0][3:0] player_state;
  logic [3:0]      player_valid;
  logic            update_pulse;
  logic [1:0]      update_id;
  logic [7:0]      crc_err_count, frame_err_count;

  int total = 0;
  int bad   = 0;

  // Reference model of the player registers and counters.
  logic [8:0] exp_x [4];
  logic [8:0] exp_y [4];
  logic [1:0] exp_dir [4];
  logic [3:0] exp_st [4];
  logic [3:0] exp_valid;
  logic [7:0] exp_crc, exp_frame;
  logic [1:0] exp_last;
  int         exp_pulses = 0;

  // Observed commit strobes and raw byte strobes.
  int         pulse_cnt = 0;
  logic [1:0] last_pid = 2'd0;
  int         bv_cnt = 0;

  // Current packet under construction.
  logic [7:0] pkt [6];
  logic [1:0] p_id, p_dir;
  logic [3:0] p_st;
  logic [8:0] p_x, p_y;

  player_state_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(20)
  ) u_dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rx_in          (rx_in),
    .local_player_ID(local_id),
    .player_x       (player_x),
    .player_y       (player_y),
    .player_dir     (player_dir),
    .player_state   (player_state),
    .player_valid   (player_valid),
    .update_pulse   (update_pulse),
    .update_id      (update_id),
    .crc_err_count  (crc_err_count),
    .frame_err_count(frame_err_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_n && update_pulse) begin
      pulse_cnt++;
      last_pid = update_id;
    end
    if (reset_n && u_dut.byte_valid) bv_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "time limit");
  end

  task automatic model_clear();
    for (int s = 0; s < 4; s++) begin
      exp_x[s] = '0; exp_y[s] = '0; exp_dir[s] = '0; exp_st[s] = '0;
    end
    exp_valid = '0; exp_crc = '0; exp_frame = '0; exp_last = '0;
  endtask

  task automatic model_pkt(input logic good);
    if (!good) begin
      if (exp_crc != 8'hFF) exp_crc++;
    end else if (p_id != local_id) begin
      exp_x[p_id] = p_x; exp_y[p_id] = p_y; exp_dir[p_id] = p_dir; exp_st[p_id] = p_st;
      exp_valid[p_id] = 1'b1;
      exp_last = p_id;
      exp_pulses++;
    end
  endtask

  task automatic make_pkt(input logic [1:0] id, input logic [1:0] dir, input logic [3:0] st,
                          input logic [8:0] x, input logic [8:0] y, input logic [5:0] res,
                          input logic [7:0] csum_flip);
    p_id = id; p_dir = dir; p_st = st; p_x = x; p_y = y;
    pkt[0] = 8'hA5;
    pkt[1] = {id, dir, st};
    pkt[2] = x[7:0];
    pkt[3] = {x[8], y[8], res};
    pkt[4] = y[7:0];
    pkt[5] = pkt[1] ^ pkt[2] ^ pkt[3] ^ pkt[4] ^ csum_flip;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx_in = stop;
    repeat (CPB) @(negedge clock);
    rx_in = 1'b1;
  endtask

  task automatic send_pkt();
    for (int i = 0; i < 6; i++) send_byte(pkt[i], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    rx_in = 1'b1;
    repeat (n * CPB) @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx_in   = 1'b1;
    model_clear();
    repeat (3) @(negedge clock);
    total++;
    if ({player_x, player_y, player_dir, player_state} !== '0) begin
      bad++; $display("FAIL reset_fields: got %h want 0", {player_x, player_y});
    end
    total++;
    if ({player_valid, update_pulse, update_id} !== '0) begin
      bad++; $display("FAIL reset_status: got %b want 0", {player_valid, update_pulse, update_id});
    end
    total++;
    if ({crc_err_count, frame_err_count} !== 16'h0) begin
      bad++; $display("FAIL reset_counts: got %h want 0000", {crc_err_count, frame_err_count});
    end
    reset_n = 1'b1;
    idle_bits(2);
  endtask

  task automatic test_good();
    local_id = 2'd0;
    make_pkt(2'd2, 2'd1, 4'd5, 9'd300, 9'd200, 6'd0, 8'h00);
    send_pkt();
    model_pkt(1'b1);
    idle_bits(2);
    for (int s = 0; s < 4; s++) begin
      total++;
      if ({player_x[s], player_y[s], player_dir[s], player_state[s]} !==
          {exp_x[s], exp_y[s], exp_dir[s], exp_st[s]}) begin
        bad++; $display("FAIL good_slot%0d: got x=%0d y=%0d want x=%0d y=%0d", s,
                        player_x[s], player_y[s], exp_x[s], exp_y[s]);
      end
    end
    total++;
    if (player_valid !== 4'b0100) begin
      bad++; $display("FAIL good_valid: got %b want 0100", player_valid);
    end
    total++;
    if (pulse_cnt !== exp_pulses || last_pid !== 2'd2 || update_pulse !== 1'b0) begin
      bad++; $display("FAIL good_pulse: got cnt=%0d id=%0d want cnt=%0d id=2", pulse_cnt,
                      last_pid, exp_pulses);
    end
  endtask

  task automatic test_bad_csum();
    make_pkt(2'd2, 2'd3, 4'd9, 9'd17, 9'd401, 6'd0, 8'h00);
    pkt[5] = 8'h00;
    send_pkt();
    model_pkt(1'b0);
    idle_bits(1);
    total++;
    if (crc_err_count !== exp_crc || player_x[2] !== exp_x[2] || pulse_cnt !== exp_pulses) begin
      bad++; $display("FAIL crc_drop: got crc=%0d x2=%0d pulses=%0d want crc=%0d x2=%0d pulses=%0d",
                      crc_err_count, player_x[2], pulse_cnt, exp_crc, exp_x[2], exp_pulses);
    end
    make_pkt(2'd1, 2'd2, 4'd12, 9'd511, 9'd1, 6'd0, 8'h00);
    send_pkt();
    model_pkt(1'b1);
    idle_bits(2);
    total++;
    if ({player_x[1], player_y[1], player_dir[1], player_state[1]} !==
        {exp_x[1], exp_y[1], exp_dir[1], exp_st[1]} || player_valid !== exp_valid) begin
      bad++; $display("FAIL crc_recover: got x=%0d valid=%b want x=%0d valid=%b", player_x[1],
                      player_valid, exp_x[1], exp_valid);
    end
  endtask

  task automatic test_frame();
    make_pkt(2'd3, 2'd0, 4'd1, 9'd99, 9'd88, 6'd0, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(pkt[i], 1'b1);
    send_byte(pkt[3], 1'b0);
    exp_frame++;
    idle_bits(4);
    total++;
    if (frame_err_count !== exp_frame || pulse_cnt !== exp_pulses || crc_err_count !== exp_crc) begin
      bad++; $display("FAIL frame_stop: got fe=%0d pulses=%0d want fe=%0d pulses=%0d",
                      frame_err_count, pulse_cnt, exp_frame, exp_pulses);
    end
    rx_in = 1'b0;
    repeat (30 * CPB) @(negedge clock);
    exp_frame++;
    idle_bits(4);
    total++;
    if (frame_err_count !== exp_frame) begin
      bad++; $display("FAIL frame_break: got %0d want %0d", frame_err_count, exp_frame);
    end
    make_pkt(2'd1, 2'd1, 4'd7, 9'd256, 9'd300, 6'd0, 8'h00);
    send_pkt();
    model_pkt(1'b1);
    idle_bits(2);
    total++;
    if ({player_x[1], player_y[1], player_dir[1], player_state[1]} !==
        {exp_x[1], exp_y[1], exp_dir[1], exp_st[1]} || pulse_cnt !== exp_pulses) begin
      bad++; $display("FAIL frame_recover: got x=%0d y=%0d want x=%0d y=%0d", player_x[1],
                      player_y[1], exp_x[1], exp_y[1]);
    end
  endtask

  task automatic test_local();
    local_id = 2'd3;
    make_pkt(2'd3, 2'd2, 4'd4, 9'd123, 9'd321, 6'd0, 8'h00);
    send_pkt();
    model_pkt(1'b1);
    idle_bits(2);
    total++;
    if (player_valid !== exp_valid || player_x[3] !== exp_x[3] || pulse_cnt !== exp_pulses) begin
      bad++; $display("FAIL local_drop: got valid=%b pulses=%0d want valid=%b pulses=%0d",
                      player_valid, pulse_cnt, exp_valid, exp_pulses);
    end
    total++;
    if (crc_err_count !== exp_crc || frame_err_count !== exp_frame) begin
      bad++; $display("FAIL local_counts: got crc=%0d fe=%0d want crc=%0d fe=%0d",
                      crc_err_count, frame_err_count, exp_crc, exp_frame);
    end
    local_id = 2'd0;
  endtask

  task automatic test_timeout();
    int bv0;
    make_pkt(2'd3, 2'd1, 4'd2, 9'd40, 9'd50, 6'd0, 8'h00);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(pkt[i], 1'b1);
    idle_bits(25);
    make_pkt(2'd3, 2'd3, 4'd14, 9'd444, 9'd333, 6'd0, 8'h00);
    send_pkt();
    model_pkt(1'b1);
    idle_bits(2);
    total++;
    if ({player_x[3], player_y[3], player_dir[3], player_state[3]} !==
        {exp_x[3], exp_y[3], exp_dir[3], exp_st[3]} || pulse_cnt !== exp_pulses) begin
      bad++; $display("FAIL timeout_commit: got x=%0d pulses=%0d want x=%0d pulses=%0d",
                      player_x[3], pulse_cnt, exp_x[3], exp_pulses);
    end
    total++;
    if (crc_err_count !== exp_crc || frame_err_count !== exp_frame) begin
      bad++; $display("FAIL timeout_counts: got crc=%0d fe=%0d want crc=%0d fe=%0d",
                      crc_err_count, frame_err_count, exp_crc, exp_frame);
    end
    bv0 = bv_cnt;
    rx_in = 1'b0;
    repeat (CPB / 2 - 1) @(negedge clock);
    idle_bits(4);
    total++;
    if (bv_cnt !== bv0 || frame_err_count !== exp_frame) begin
      bad++; $display("FAIL glitch: got bytes=%0d fe=%0d want bytes=%0d fe=%0d", bv_cnt - bv0,
                      frame_err_count, 0, exp_frame);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      int kind;
      logic [1:0] id;
      kind = $urandom_range(0, 3);
      local_id = 2'($urandom_range(0, 3));
      id = (kind == 3) ? local_id : 2'(local_id + $urandom_range(1, 3));
      make_pkt(id, 2'($urandom), 4'($urandom), 9'($urandom), 9'($urandom), 6'($urandom),
               (kind == 2) ? 8'($urandom_range(1, 255)) : 8'h00);
      send_pkt();
      model_pkt(kind != 2);
      idle_bits(2);
      for (int s = 0; s < 4; s++) begin
        total++;
        if ({player_x[s], player_y[s], player_dir[s], player_state[s]} !==
            {exp_x[s], exp_y[s], exp_dir[s], exp_st[s]}) begin
          bad++; $display("FAIL rand%0d_slot%0d: got x=%0d y=%0d d=%0d s=%0d want x=%0d y=%0d d=%0d s=%0d",
                          n, s, player_x[s], player_y[s], player_dir[s], player_state[s],
                          exp_x[s], exp_y[s], exp_dir[s], exp_st[s]);
        end
      end
      total++;
      if (player_valid !== exp_valid || crc_err_count !== exp_crc || pulse_cnt !== exp_pulses ||
          (exp_pulses > 0 && update_id !== exp_last)) begin
        bad++; $display("FAIL rand%0d_status: got v=%b crc=%0d p=%0d id=%0d want v=%b crc=%0d p=%0d id=%0d",
                        n, player_valid, crc_err_count, pulse_cnt, update_id, exp_valid, exp_crc,
                        exp_pulses, exp_last);
      end
    end
    local_id = 2'd0;
  endtask

  task automatic test_reset_mid();
    make_pkt(2'd2, 2'd2, 4'd3, 9'd10, 9'd20, 6'd0, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(pkt[i], 1'b1);
    reset_n = 1'b0;
    #1;
    total++;
    if ({player_x, player_y, player_dir, player_state, player_valid} !== '0 ||
        {update_pulse, update_id, crc_err_count, frame_err_count} !== '0) begin
      bad++; $display("FAIL reset_mid: got valid=%b crc=%0d fe=%0d want all zero", player_valid,
                      crc_err_count, frame_err_count);
    end
    model_clear();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle_bits(2);
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 260; n++) begin
      make_pkt(2'($urandom), 2'($urandom), 4'($urandom), 9'($urandom), 9'($urandom), 6'd0, 8'h01);
      send_pkt();
      model_pkt(1'b0);
      if (n == 253) begin
        idle_bits(1);
        total++;
        if (crc_err_count !== exp_crc) begin
          bad++; $display("FAIL sat_254: got %0d want %0d", crc_err_count, exp_crc);
        end
      end
    end
    idle_bits(2);
    total++;
    if (crc_err_count !== 8'd255 || crc_err_count !== exp_crc) begin
      bad++; $display("FAIL sat_hold: got %0d want 255", crc_err_count);
    end
    total++;
    if (player_valid !== 4'b0000 || pulse_cnt !== exp_pulses) begin
      bad++; $display("FAIL sat_nowrite: got valid=%b pulses=%0d want valid=0000 pulses=%0d",
                      player_valid, pulse_cnt, exp_pulses);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_good();
    test_bad_csum();
    test_frame();
    test_local();
    test_timeout();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
